// File: rtl/risky_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// memory-map region field carried in the top address bits.
package risky_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RMW_RD,
        RMW_WR,
        RESP
    } state_e;

    localparam logic [5:0] REGION_ROM  = 6'd0;
    localparam logic [5:0] REGION_RAM  = 6'd1;
    localparam logic [5:0] REGION_MMIO = 6'd2;

    // Reserved size or an address not naturally aligned to the access size.
    function automatic logic access_err(input size_e size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            SZ_WORD: return lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/risky_lsu_align.sv
// Little-endian lane handling: extracts and extends load data, and merges
// right-aligned store data into the addressed lanes of a bus word.
module risky_lsu_align
    import risky_pkg::*;
(
    input  logic [31:0] rd_word,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;

    always_comb begin
        shamt     = 5'd0;
        mask      = '1;
        case (size)
            SZ_BYTE: begin
                shamt = {lane, 3'b000};
                mask  = 32'h0000_00FF << shamt;
            end
            SZ_HALF: begin
                shamt = {lane[1], 4'b0000};
                mask  = 32'h0000_FFFF << shamt;
            end
            default: ;
        endcase

        shifted   = rd_word >> shamt;
        load_data = rd_word;
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase

        merged = (rd_word & ~mask) | ((wdata << shamt) & mask);
    end

endmodule

// File: rtl/risky_lsu.sv
// Single-outstanding load/store unit on a shared tristate bus; sub-word stores
// are done as read-modify-write so the responder only ever sees whole words.
module risky_lsu
    import risky_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    inout  wire  [31:0]       mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_oe,
    output logic              mem_we
);

    state_e      state;
    size_e       size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [31:0] wbus_q;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic        accept;
    logic        req_err;
    logic [ADDR_W-1:0] word_addr;

    // Ready is gated by rst_n so it stays low throughout reset even though
    // the state register already sits in IDLE.
    assign req_ready = rst_n && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign req_err   = access_err(size_e'(req_size), req_addr[1:0]);
    assign word_addr = {req_addr[ADDR_W-1 -: 6], 2'b00, req_addr[ADDR_W-7:2]};
    assign mem_data  = mem_we ? wbus_q : 32'bz;

    risky_lsu_align u_align (
        .rd_word     (mem_data),
        .size        (size_q),
        .is_unsigned (uns_q),
        .lane        (lane_q),
        .wdata       (wbus_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_oe    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_err) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            mem_addr <= word_addr;
                            if (!req_we) begin
                                state  <= READ;
                                mem_oe <= 1'b1;
                            end else if (size_e'(req_size) == SZ_WORD) begin
                                state  <= WRITE;
                                mem_we <= 1'b1;
                            end else begin
                                state  <= RMW_RD;
                                mem_oe <= 1'b1;
                            end
                        end
                    end
                end
                READ: begin
                    mem_oe    <= 1'b0;
                    mem_addr  <= '0;
                    rsp_rdata <= load_data;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                WRITE, RMW_WR: begin
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RMW_RD: begin
                    mem_oe <= 1'b0;
                    mem_we <= 1'b1;
                    state  <= RMW_WR;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request fields and the outgoing bus word; the RMW read replaces the
    // store data with the merged word that RMW_WR then drives.
    always_ff @(posedge clk) begin
        if (accept) begin
            size_q <= size_e'(req_size);
            uns_q  <= req_unsigned;
            lane_q <= req_addr[1:0];
            wbus_q <= req_wdata;
        end else if (state == RMW_RD) begin
            wbus_q <= merged;
        end
    end

endmodule

// File: doc/risky_lsu.md
RISKY_LSU -- requirements
Module: risky_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the width of byte addresses and of mem_addr.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1, core presents a load/store request.
REQ-005 SHALL have port req_ready, output, 1, LSU accepts a request this cycle.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2: 0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-008 SHALL have port req_unsigned, input, 1: zero-extend loads when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr, input, ADDR_W, the byte address.
REQ-010 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-011 SHALL have port rsp_valid, output, 1, one-cycle completion pulse with no backpressure.
REQ-012 SHALL have port rsp_rdata, output, 32, the extended load result; 0 for stores and errors.
REQ-013 SHALL have port rsp_err, output, 1, misaligned access or reserved size; qualified by rsp_valid.
REQ-014 SHALL have port mem_data, inout, 32, the shared bus data.
REQ-015 SHALL have port mem_addr, output, ADDR_W, the word address {req_addr[31:26], 2'b00, req_addr[25:2]}, which preserves the region field (0 = ROM, 1 = RAM, 2 = MMIO).
REQ-016 SHALL have port mem_oe, output, 1, read strobe; the responder drives mem_data combinationally while it is high.
REQ-017 SHALL have port mem_we, output, 1, write strobe; the responder captures mem_data at the rising edge while it is high.

Function
REQ-018 SHALL implement states IDLE, READ, WRITE, RMW_RD, RMW_WR, RESP.
REQ-019 SHALL assert req_ready only in IDLE; a request is accepted on an edge where req_valid and req_ready are both high, and request fields are registered at acceptance.
REQ-020 SHALL flag an error when req_size is 3, when a half access has addr[0] set, or when a word access has addr[1:0] nonzero; error requests go IDLE->RESP with no bus cycle and rsp_err=1.
REQ-021 SHALL route an accepted load to READ for one cycle with mem_oe=1, sample mem_data at the end of that cycle, then enter RESP.
REQ-022 SHALL route an accepted word store to WRITE for one cycle with mem_we=1, drive req_wdata on mem_data, then enter RESP.
REQ-023 SHALL handle an accepted byte or half store by read-modify-write: RMW_RD for one cycle with mem_oe=1 to capture the word, RMW_WR for one cycle with mem_we=1 driving the merged word with only the addressed lanes replaced, then RESP.
REQ-024 SHALL select lanes little-endian: byte lane = addr[1:0], half lane = addr[1].
REQ-025 SHALL assert rsp_valid in RESP for exactly one cycle, then return to IDLE.
REQ-026 SHALL give latency from the acceptance edge to the rsp_valid cycle of 1 for errors, 2 for loads and word stores, and 3 for sub-word stores.
REQ-027 SHALL drive mem_data only while mem_we=1 and hold it at high-Z otherwise; mem_oe and mem_we SHALL never both be high.
REQ-028 SHALL hold mem_addr stable through both cycles of an RMW and drive it to 0 when idle.
REQ-029 SHALL ignore req_valid outside IDLE, so back-to-back requests are separated by the RESP cycle.

Reset
REQ-030 SHALL, while rst_n=0, force state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_oe=0, mem_we=0, mem_addr=0 and mem_data to high-Z.
REQ-031 SHALL abort any operation when reset asserts mid-operation with no further bus strobe; an RMW aborted in RMW_RD SHALL never write.
REQ-032 SHALL assert req_ready in the first cycle after rst_n deasserts.

Structure
REQ-033 SHALL place the size encodings, the state enum and the region constants (ROM=0, RAM=1, MMIO=2) in shared package risky_pkg.
REQ-034 SHALL implement lane extraction, sign/zero extension and store merge in a combinational sub-module risky_lsu_align.

Verification
REQ-035 SHALL check: word load of addr 0x0400_0008 with RAM word[2]=0xDEADBEEF -> mem_addr=0x0400_0002, mem_oe for one cycle, rsp_rdata=0xDEADBEEF two cycles after acceptance.
REQ-036 SHALL check: signed byte load of addr 0x0400_0003 from word 0x80FF_1234 -> rsp_rdata=0xFFFFFF80; the same load unsigned -> 0x00000080.
REQ-037 SHALL check: half store of 0xABCD to addr 0x0400_0002 over word 0x11223344 -> RMW_RD then RMW_WR, RAM word becomes 0xABCD3344, rsp_valid at +3.
REQ-038 SHALL check: word store to addr 0x0400_0001 -> rsp_err=1 at +1, no mem_oe or mem_we pulse, memory unchanged.
REQ-039 SHALL check: reset asserted in the RMW_RD cycle -> mem_we is never raised, memory unchanged, req_ready=1 in the first cycle after release.
REQ-040 SHALL check: byte store of 0x41 to the MMIO region (addr 0x0800_0008) -> mem_addr=0x0800_0002 on both RMW cycles and the low byte of the merged word is 0x41.
